// File: rtl/usb_buffer_scheduler.sv
// usb_buffer_scheduler
// Arbitrates the shared endpoint data buffer between the AHB slave side and
// the USB TX encoder / RX decoder. It tracks which side owns the buffer, keeps
// the fill/drain pointers and occupancy count, launches TX packets, and issues
// the buffer write/read strobes with address and byte count.
//
// Ports:
//   clk, rst             - system clock (rising edge), async active-high reset
//   storeTxData          - AHB write of N = 1<<dataSize bytes this cycle
//   getRxData            - AHB read of N = 1<<dataSize bytes this cycle
//   dataSize             - AHB access size code (0:1, 1:2, 2:4 bytes)
//   txPacketSize         - number of bytes to transmit
//   txPacketSizeChanged  - launch request for a TX packet
//   txBytePop            - TX encoder consumes one byte
//   rxBytePush           - RX decoder delivers one byte
//   rxPacketDone         - end of received packet
//   flush                - discard buffer contents, return to idle
//   bufWrEn, bufRdEn     - buffer strobes (combinational)
//   bufAddr              - byte address of the access (combinational)
//   bufByteCount         - bytes in the access, 0 when no strobe (combinational)
//   ahbStall             - AHB access held off while USB owns the buffer
//   startTx, txDone      - registered one-cycle pulses around a TX packet
//   rxDataReady          - received packet waiting for the host to drain it
//   occupancy            - bytes currently held
//   errorFlag            - registered one-cycle pulse on any rejected event

module usb_buffer_scheduler #(
    parameter int BUF_BYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          storeTxData,
    input  logic                          getRxData,
    input  logic [1:0]                    dataSize,
    input  logic [$clog2(BUF_BYTES):0]    txPacketSize,
    input  logic                          txPacketSizeChanged,
    input  logic                          txBytePop,
    input  logic                          rxBytePush,
    input  logic                          rxPacketDone,
    input  logic                          flush,
    output logic                          bufWrEn,
    output logic                          bufRdEn,
    output logic [$clog2(BUF_BYTES)-1:0]  bufAddr,
    output logic [2:0]                    bufByteCount,
    output logic                          ahbStall,
    output logic                          startTx,
    output logic                          txDone,
    output logic                          rxDataReady,
    output logic [$clog2(BUF_BYTES):0]    occupancy,
    output logic                          errorFlag
);

    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_BYTES);
    localparam logic [OCC_W-1:0] ONE  = OCC_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        HOST_FILL,
        TX_SEND,
        RX_RECV,
        HOST_DRAIN
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] tx_remaining;

    logic [2:0]       ahb_bytes;
    logic [OCC_W-1:0] ahb_bytes_ext;
    logic             wr_ahb;
    logic             wr_usb;
    logic             rd_ahb;
    logic             rd_usb;
    logic             launch_ok;
    logic             reject;
    logic [OCC_W-1:0] wr_step;
    logic [OCC_W-1:0] rd_step;
    logic [OCC_W-1:0] occ_after;

    // AHB access size in bytes; code 3 is never presented.
    always_comb begin
        case (dataSize)
            2'd0:    ahb_bytes = 3'd1;
            2'd1:    ahb_bytes = 3'd2;
            default: ahb_bytes = 3'd4;
        endcase
    end

    assign ahb_bytes_ext = OCC_W'(ahb_bytes);

    // Decide which access is accepted this cycle and whether anything is
    // rejected. Flush overrides everything, so no strobe or error is raised
    // in the flush cycle. In HOST_FILL the launch check uses the pre-write
    // occupancy, so a simultaneous write cannot enable its own launch.
    always_comb begin
        wr_ahb    = 1'b0;
        wr_usb    = 1'b0;
        rd_ahb    = 1'b0;
        rd_usb    = 1'b0;
        launch_ok = 1'b0;
        reject    = 1'b0;
        ahbStall  = 1'b0;
        if (!flush) begin
            case (state)
                IDLE: begin
                    if (rxBytePush) begin
                        wr_usb   = 1'b1;
                        ahbStall = storeTxData;
                    end else if (storeTxData) begin
                        wr_ahb = 1'b1;
                    end
                    if (getRxData || txPacketSizeChanged) begin
                        reject = 1'b1;
                    end
                end
                HOST_FILL: begin
                    if (storeTxData) begin
                        if (occupancy + ahb_bytes_ext <= FULL) begin
                            wr_ahb = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    if (txPacketSizeChanged) begin
                        if (txPacketSize != '0 && txPacketSize <= occupancy) begin
                            launch_ok = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    if (rxBytePush || getRxData) begin
                        reject = 1'b1;
                    end
                end
                TX_SEND: begin
                    ahbStall = storeTxData || getRxData;
                    rd_usb   = txBytePop;
                    reject   = rxBytePush;
                end
                RX_RECV: begin
                    ahbStall = storeTxData || getRxData;
                    if (rxBytePush) begin
                        if (occupancy < FULL) begin
                            wr_usb = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                HOST_DRAIN: begin
                    if (getRxData) begin
                        if (ahb_bytes_ext <= occupancy) begin
                            rd_ahb = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    if (storeTxData || rxBytePush) begin
                        reject = 1'b1;
                    end
                end
                default: begin
                    reject = 1'b0;
                end
            endcase
        end
    end

    assign bufWrEn = wr_ahb || wr_usb;
    assign bufRdEn = rd_ahb || rd_usb;
    assign bufAddr = bufWrEn ? wr_ptr : (bufRdEn ? rd_ptr : '0);

    always_comb begin
        if (wr_ahb || rd_ahb) begin
            bufByteCount = ahb_bytes;
        end else if (wr_usb || rd_usb) begin
            bufByteCount = 3'd1;
        end else begin
            bufByteCount = 3'd0;
        end
    end

    assign wr_step   = wr_ahb ? ahb_bytes_ext : (wr_usb ? ONE : '0);
    assign rd_step   = rd_ahb ? ahb_bytes_ext : (rd_usb ? ONE : '0);
    assign occ_after = occupancy + wr_step - rd_step;

    // Ownership state machine with pointer/occupancy bookkeeping. Pointers
    // advance by default and the terminating transitions overwrite them with
    // zero so every packet starts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            tx_remaining <= '0;
            startTx      <= 1'b0;
            txDone       <= 1'b0;
            rxDataReady  <= 1'b0;
            errorFlag    <= 1'b0;
        end else begin
            startTx   <= 1'b0;
            txDone    <= 1'b0;
            errorFlag <= reject;
            if (flush) begin
                state        <= IDLE;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                occupancy    <= '0;
                tx_remaining <= '0;
                rxDataReady  <= 1'b0;
            end else begin
                wr_ptr    <= wr_ptr + wr_step[PTR_W-1:0];
                rd_ptr    <= rd_ptr + rd_step[PTR_W-1:0];
                occupancy <= occ_after;
                case (state)
                    IDLE: begin
                        if (wr_usb) begin
                            state <= RX_RECV;
                        end else if (wr_ahb) begin
                            state <= HOST_FILL;
                        end
                    end
                    HOST_FILL: begin
                        if (launch_ok) begin
                            startTx      <= 1'b1;
                            tx_remaining <= txPacketSize;
                            rd_ptr       <= '0;
                            state        <= TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        if (rd_usb) begin
                            if (tx_remaining == ONE) begin
                                // Last byte: anything written past the packet length is dropped.
                                txDone       <= 1'b1;
                                wr_ptr       <= '0;
                                rd_ptr       <= '0;
                                occupancy    <= '0;
                                tx_remaining <= '0;
                                state        <= IDLE;
                            end else begin
                                tx_remaining <= tx_remaining - ONE;
                            end
                        end
                    end
                    RX_RECV: begin
                        if (rxPacketDone) begin
                            if (occ_after != '0) begin
                                rxDataReady <= 1'b1;
                                state       <= HOST_DRAIN;
                            end else begin
                                wr_ptr    <= '0;
                                rd_ptr    <= '0;
                                occupancy <= '0;
                                state     <= IDLE;
                            end
                        end
                    end
                    HOST_DRAIN: begin
                        if (rd_ahb && occ_after == '0) begin
                            rxDataReady <= 1'b0;
                            wr_ptr      <= '0;
                            rd_ptr      <= '0;
                            state       <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
